rf_wr_arb: RTL and testbench

Register-file write-port arbiter for the Beta pipeline. It sits between the write-back stage and the single register-file write port, and shares that port among three requesters: the pipeline WB stage, the multiply/divide unit (MDU) and the debug port. WB always has priority and is never back-pressured. The MDU and debug port are served round-robin in free slots. A starvation timer requests a pipeline bubble when a secondary requester has waited too long.

---
 rtl/rf_wr_arb_pkg.sv | 27 ++
 rtl/rf_wr_starve_tmr.sv | 55 +++++
 rtl/rf_wr_arb.sv | 94 +++++++++
 tb/tb_rf_wr_arb.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rf_wr_arb_pkg.sv
// Shared encodings and types for the register-file write-port arbiter.
// R31 is hardwired zero, so writes to it are acknowledged but never reach the port.
package rf_wr_arb_pkg;

    localparam logic [4:0] REG_ZERO = 5'd31;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_STARVE = 1'b1
    } arb_state_e;

    typedef enum logic {
        REQ_MDU = 1'b0,
        REQ_DBG = 1'b1
    } req_e;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } rf_wr_t;

    // A request that actually needs the write port (valid and not aimed at R31).
    function automatic logic needs_port(input logic valid, input logic [4:0] addr);
        return valid && (addr != REG_ZERO);
    endfunction

endpackage

// File: rtl/rf_wr_starve_tmr.sv
// Wait counter and IDLE/STARVE FSM; raises stall_req once a secondary requester
// has waited STARVE_LIMIT consecutive cycles, until it is served or withdraws.
module rf_wr_starve_tmr
    import rf_wr_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_waiting,
    input  logic i_sec_grant,
    input  logic i_sec_valid,
    output logic o_stall_req
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_wait_cnt;
    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic             w_cnt_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (i_sec_grant || !i_waiting) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != LIMIT) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    // True on the edge at which the counter reaches the limit (saturation holds it there).
    assign w_cnt_hit = i_waiting && !i_sec_grant && (r_wait_cnt == LIMIT - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ARB_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE:   if (w_cnt_hit) w_state_nxt = ARB_STARVE;
            ARB_STARVE: if (i_sec_grant || !i_sec_valid) w_state_nxt = ARB_IDLE;
            default:    w_state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        o_stall_req = (r_state == ARB_STARVE);
    end

endmodule

// File: rtl/rf_wr_arb.sv
// Shares the single register-file write port between WB (absolute priority),
// the MDU and the debug port (round-robin in free slots). Write path is combinational.
module rf_wr_arb
    import rf_wr_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_addr,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    input  logic        dbg_valid,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_data,
    output logic        dbg_ready,
    output logic        stall_req,
    output logic        rf_we,
    output logic [4:0]  rf_w_addr,
    output logic [31:0] rf_w_data
);

    req_e   r_rr_last;
    logic   w_wb_real;
    logic   w_mdu_real;
    logic   w_dbg_real;
    logic   w_gnt_mdu;
    logic   w_gnt_dbg;
    logic   w_sec_grant;
    logic   w_waiting;
    rf_wr_t w_wr;

    assign w_wb_real  = needs_port(wb_we, wb_addr);
    assign w_mdu_real = needs_port(mdu_valid, mdu_addr);
    assign w_dbg_real = needs_port(dbg_valid, dbg_addr);

    // Secondary grants only in slots WB leaves free; on a tie the one not served last wins.
    always_comb begin
        w_gnt_mdu = 1'b0;
        w_gnt_dbg = 1'b0;
        if (!w_wb_real) begin
            if (w_mdu_real && w_dbg_real) begin
                w_gnt_mdu = (r_rr_last == REQ_DBG);
                w_gnt_dbg = (r_rr_last == REQ_MDU);
            end else begin
                w_gnt_mdu = w_mdu_real;
                w_gnt_dbg = w_dbg_real;
            end
        end
    end

    assign w_sec_grant = w_gnt_mdu || w_gnt_dbg;

    always_comb begin
        w_wr = '{addr: wb_addr, data: wb_data};
        if (w_gnt_mdu)      w_wr = '{addr: mdu_addr, data: mdu_data};
        else if (w_gnt_dbg) w_wr = '{addr: dbg_addr, data: dbg_data};
    end

    // Strobes are gated by rst_n so they drop asynchronously during reset.
    always_comb begin
        rf_we     = rst_n && (w_wb_real || w_sec_grant);
        rf_w_addr = w_wr.addr;
        rf_w_data = w_wr.data;
        mdu_ready = rst_n && (w_gnt_mdu || (mdu_valid && mdu_addr == REG_ZERO));
        dbg_ready = rst_n && (w_gnt_dbg || (dbg_valid && dbg_addr == REG_ZERO));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_rr_last <= REQ_DBG;
        else if (w_gnt_mdu) r_rr_last <= REQ_MDU;
        else if (w_gnt_dbg) r_rr_last <= REQ_DBG;
    end

    assign w_waiting = (mdu_valid && !mdu_ready) || (dbg_valid && !dbg_ready);

    rf_wr_starve_tmr #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_starve_tmr (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_waiting    (w_waiting),
        .i_sec_grant  (w_sec_grant),
        .i_sec_valid  (mdu_valid || dbg_valid),
        .o_stall_req  (stall_req)
    );

endmodule

// File: tb/tb_rf_wr_arb.sv
// Directed bench for rf_wr_arb: a vector table for the per-cycle write path and
// hand-written sequences for starvation and reset in the middle of STARVE.
module tb_rf_wr_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        mdu_valid = 1'b0;
    logic [4:0]  mdu_addr = '0;
    logic [31:0] mdu_data = '0;
    logic        mdu_ready;
    logic        dbg_valid = 1'b0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data = '0;
    logic        dbg_ready;
    logic        stall_req;
    logic        rf_we;
    logic [4:0]  rf_w_addr;
    logic [31:0] rf_w_data;

    int n_tests = 0;
    int n_fail  = 0;

    rf_wr_arb #(.STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .mdu_valid (mdu_valid),
        .mdu_addr  (mdu_addr),
        .mdu_data  (mdu_data),
        .mdu_ready (mdu_ready),
        .dbg_valid (dbg_valid),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .dbg_ready (dbg_ready),
        .stall_req (stall_req),
        .rf_we     (rf_we),
        .rf_w_addr (rf_w_addr),
        .rf_w_data (rf_w_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wb_we;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        mdu_valid;
        logic [4:0]  mdu_addr;
        logic [31:0] mdu_data;
        logic        dbg_valid;
        logic [4:0]  dbg_addr;
        logic [31:0] dbg_data;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_mrdy;
        logic        e_drdy;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic dv, input logic [4:0] da, input logic [31:0] dd);
        wb_we = we;  wb_addr = wa;  wb_data = wd;
        mdu_valid = mv; mdu_addr = ma; mdu_data = md;
        dbg_valid = dv; dbg_addr = da; dbg_data = dd;
    endtask

    // Moves to the start of the next cycle (just after posedge).
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Round-robin from reset (MDU first), then WB priority, R31 rules, single requester.
        vecs[0]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,       1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd10, 32'h11,      1'b1, 5'd11, 32'h22, 1'b1, 5'd10, 32'h11,        1'b1, 1'b0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd12, 32'h33,      1'b1, 5'd11, 32'h22, 1'b1, 5'd11, 32'h22,        1'b0, 1'b1};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd12, 32'h33,      1'b1, 5'd13, 32'h44, 1'b1, 5'd12, 32'h33,        1'b1, 1'b0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd14, 32'h55,      1'b1, 5'd13, 32'h44, 1'b1, 5'd13, 32'h44,        1'b0, 1'b1};
        vecs[5]  = '{1'b1, 5'd3,  32'hAAAA_AAAA, 1'b1, 5'd4,  32'h1234,    1'b0, 5'd0,  32'h0,  1'b1, 5'd3,  32'hAAAA_AAAA, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 5'd3,  32'hAAAA_AAAA, 1'b1, 5'd4,  32'h1234,    1'b0, 5'd0,  32'h0,  1'b1, 5'd4,  32'h1234,      1'b1, 1'b0};
        vecs[7]  = '{1'b1, 5'd5,  32'h5555,      1'b1, 5'd31, 32'hDEAD,    1'b0, 5'd0,  32'h0,  1'b1, 5'd5,  32'h5555,      1'b1, 1'b0};
        vecs[8]  = '{1'b1, 5'd31, 32'h9999,      1'b0, 5'd0,  32'h0,       1'b1, 5'd7,  32'h77, 1'b1, 5'd7,  32'h77,        1'b0, 1'b1};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd31, 32'h1,       1'b1, 5'd31, 32'h2,  1'b0, 5'd0,  32'h0,         1'b1, 1'b1};
        vecs[10] = '{1'b1, 5'd31, 32'h3,         1'b1, 5'd31, 32'h1,       1'b1, 5'd31, 32'h2,  1'b0, 5'd0,  32'h0,         1'b1, 1'b1};
        vecs[11] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,       1'b1, 5'd8,  32'h88, 1'b1, 5'd8,  32'h88,        1'b0, 1'b1};
        vecs[12] = '{1'b1, 5'd6,  32'h6666,      1'b1, 5'd9,  32'h99,      1'b1, 5'd31, 32'h3,  1'b1, 5'd6,  32'h6666,      1'b0, 1'b1};

        // Outputs held low while in reset.
        #2;
        check("reset_rf_we", 32'(rf_we), 32'h0);
        check("reset_stall", 32'(stall_req), 32'h0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            next_cycle();
            drive(vecs[i].wb_we, vecs[i].wb_addr, vecs[i].wb_data,
                  vecs[i].mdu_valid, vecs[i].mdu_addr, vecs[i].mdu_data,
                  vecs[i].dbg_valid, vecs[i].dbg_addr, vecs[i].dbg_data);
            @(negedge clk);
            check($sformatf("v%0d_rf_we", i), 32'(rf_we), 32'(vecs[i].e_we));
            check($sformatf("v%0d_mdu_ready", i), 32'(mdu_ready), 32'(vecs[i].e_mrdy));
            check($sformatf("v%0d_dbg_ready", i), 32'(dbg_ready), 32'(vecs[i].e_drdy));
            if (vecs[i].e_we) begin
                check($sformatf("v%0d_rf_w_addr", i), 32'(rf_w_addr), 32'(vecs[i].e_addr));
                check($sformatf("v%0d_rf_w_data", i), rf_w_data, vecs[i].e_data);
            end
        end

        // Starvation: WB writes R2 every cycle, MDU waits on R9 from cycle 1.
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            drive(1'b1, 5'd2, 32'h2222, 1'b1, 5'd9, 32'h9999_0009, 1'b0, 5'd0, 32'h0);
            @(negedge clk);
            check($sformatf("starve_c%0d_stall", c), 32'(stall_req), (c >= 5) ? 32'h1 : 32'h0);
            check($sformatf("starve_c%0d_mdu_ready", c), 32'(mdu_ready), 32'h0);
        end
        next_cycle();
        wb_we = 1'b0;
        @(negedge clk);
        check("starve_c7_rf_we", 32'(rf_we), 32'h1);
        check("starve_c7_addr", 32'(rf_w_addr), 32'd9);
        check("starve_c7_data", rf_w_data, 32'h9999_0009);
        check("starve_c7_mdu_ready", 32'(mdu_ready), 32'h1);
        check("starve_c7_stall", 32'(stall_req), 32'h1);
        next_cycle();
        mdu_valid = 1'b0;
        @(negedge clk);
        check("starve_c8_stall", 32'(stall_req), 32'h0);

        // Reset in the middle of STARVE.
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            drive(1'b1, 5'd2, 32'h2222, 1'b1, 5'd9, 32'h99, 1'b1, 5'd31, 32'h0);
        end
        @(negedge clk);
        check("rst_pre_stall", 32'(stall_req), 32'h1);
        next_cycle();
        rst_n = 1'b0;
        #1;
        check("rst_now_stall", 32'(stall_req), 32'h0);
        check("rst_now_rf_we", 32'(rf_we), 32'h0);
        check("rst_now_mdu_ready", 32'(mdu_ready), 32'h0);
        check("rst_now_dbg_ready", 32'(dbg_ready), 32'h0);
        next_cycle();
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd7, 32'h77);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_after_stall", 32'(stall_req), 32'h0);
        check("rst_after_rf_we", 32'(rf_we), 32'h1);
        check("rst_after_addr", 32'(rf_w_addr), 32'd9);
        check("rst_after_mdu_ready", 32'(mdu_ready), 32'h1);
        check("rst_after_dbg_ready", 32'(dbg_ready), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
